// File: rtl/mips_defs.sv
//------------------------------------------------------------------------------
// Module      : mips_defs
// Description : Shared MIPS32 multicycle-control definitions: opcodes, FSM
//               state encodings and datapath select encodings.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_defs;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic       c_iord_pc        = 1'b0;
    localparam logic       c_iord_aluout    = 1'b1;

    localparam logic [1:0] c_pc_src_alu     = 2'b00;
    localparam logic [1:0] c_pc_src_aluout  = 2'b01;
    localparam logic [1:0] c_pc_src_jump    = 2'b10;

    localparam logic [1:0] c_reg_dst_rt     = 2'b00;
    localparam logic [1:0] c_reg_dst_rd     = 2'b01;
    localparam logic [1:0] c_reg_dst_ra     = 2'b10;

    localparam logic [1:0] c_m2r_aluout     = 2'b00;
    localparam logic [1:0] c_m2r_mdr        = 2'b01;
    localparam logic [1:0] c_m2r_pc         = 2'b10;

    localparam logic       c_alu_a_pc       = 1'b0;
    localparam logic       c_alu_a_rega     = 1'b1;

    localparam logic [1:0] c_alu_b_regb     = 2'b00;
    localparam logic [1:0] c_alu_b_four     = 2'b01;
    localparam logic [1:0] c_alu_b_sext     = 2'b10;
    localparam logic [1:0] c_alu_b_sext_sh2 = 2'b11;

    localparam logic [1:0] c_alu_op_add     = 2'b00;
    localparam logic [1:0] c_alu_op_sub     = 2'b01;
    localparam logic [1:0] c_alu_op_funct   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == c_op_rtype) || (op == c_op_lw)   || (op == c_op_sw) ||
               (op == c_op_beq)   || (op == c_op_addi) || (op == c_op_j)  ||
               (op == c_op_jal);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_out_dec.sv
//------------------------------------------------------------------------------
// Module      : ctrl_out_dec
// Description : Combinational state-to-control decoder for the multicycle FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_out_dec
    import mips_defs::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op
);

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = c_iord_pc;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        pc_src     = c_pc_src_alu;
        reg_dst    = c_reg_dst_rt;
        mem_to_reg = c_m2r_aluout;
        alu_src_a  = c_alu_a_pc;
        alu_src_b  = c_alu_b_regb;
        alu_op     = c_alu_op_add;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                // IR and PC capture only in the cycle the memory completes
                mem_req   = 1'b1;
                iord      = c_iord_pc;
                alu_src_a = c_alu_a_pc;
                alu_src_b = c_alu_b_four;
                alu_op    = c_alu_op_add;
                pc_src    = c_pc_src_alu;
                ir_we     = mem_rdy;
                pc_we     = mem_rdy;
            end
            S_DECODE: begin
                alu_src_a  = c_alu_a_pc;
                alu_src_b  = c_alu_b_sext_sh2;
                alu_op     = c_alu_op_add;
                illegal_op = ~is_legal_op(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = c_alu_a_rega;
                alu_src_b = c_alu_b_sext;
                alu_op    = c_alu_op_add;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = c_iord_aluout;
            end
            S_MEMWB: begin
                reg_dst    = c_reg_dst_rt;
                mem_to_reg = c_m2r_mdr;
                reg_we     = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = c_iord_aluout;
            end
            S_EXEC: begin
                alu_src_a = c_alu_a_rega;
                alu_src_b = c_alu_b_regb;
                alu_op    = c_alu_op_funct;
            end
            S_ALUWB: begin
                reg_dst    = c_reg_dst_rd;
                mem_to_reg = c_m2r_aluout;
                reg_we     = 1'b1;
            end
            S_ADDIWB: begin
                reg_dst    = c_reg_dst_rt;
                mem_to_reg = c_m2r_aluout;
                reg_we     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = c_alu_a_rega;
                alu_src_b = c_alu_b_regb;
                alu_op    = c_alu_op_sub;
                pc_src    = c_pc_src_aluout;
                pc_we     = zero;
            end
            S_JUMP: begin
                pc_src = c_pc_src_jump;
                pc_we  = 1'b1;
            end
            S_JAL: begin
                pc_src     = c_pc_src_jump;
                pc_we      = 1'b1;
                reg_dst    = c_reg_dst_ra;
                mem_to_reg = c_m2r_pc;
                reg_we     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module      : multicycle_ctrl
// Description : MIPS32 multicycle Moore control unit (state register,
//               next-state logic and reset gating of the enables).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t r_state;

    logic   w_mem_req;
    logic   w_mem_we;
    logic   w_ir_we;
    logic   w_pc_we;
    logic   w_reg_we;
    logic   w_illegal_op;

    // funct reaches the ALU control directly; it is not decoded here
    logic   w_unused_funct;
    assign  w_unused_funct = ^funct;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= mem_rdy ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        c_op_rtype:      r_state <= S_EXEC;
                        c_op_lw, c_op_sw: r_state <= S_MEMADR;
                        c_op_beq:        r_state <= S_BRANCH;
                        c_op_addi:       r_state <= S_ADDIEX;
                        c_op_j:          r_state <= S_JUMP;
                        c_op_jal:        r_state <= S_JAL;
                        default:         r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (opcode == c_op_lw) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= mem_rdy ? S_MEMWB : S_MEMRD;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  r_state <= mem_rdy ? S_FETCH : S_MEMWR;
                S_EXEC:   r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ADDIWB: r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                S_JAL:    r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    ctrl_out_dec u_ctrl_out_dec (
        .state      (r_state),
        .opcode     (opcode),
        .zero       (zero),
        .mem_rdy    (mem_rdy),
        .mem_req    (w_mem_req),
        .mem_we     (w_mem_we),
        .iord       (iord),
        .ir_we      (w_ir_we),
        .pc_we      (w_pc_we),
        .reg_we     (w_reg_we),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .illegal_op (w_illegal_op)
    );

    // Reset holds FETCH, whose request must not leak out while rst is high
    assign mem_req    = w_mem_req    & ~rst;
    assign mem_we     = w_mem_we     & ~rst;
    assign ir_we      = w_ir_we      & ~rst;
    assign pc_we      = w_pc_we      & ~rst;
    assign reg_we     = w_reg_we     & ~rst;
    assign illegal_op = w_illegal_op & ~rst;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl with random instruction
//               streams, random memory wait states and a mid-write reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;
    import mips_defs::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic       alu_src_a, illegal_op;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_rdy(mem_rdy), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
        P_ALUWB, P_ADDIEX, P_ADDIWB, P_BRANCH, P_JUMP, P_JAL
    } phase_t;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we;
        logic [1:0] pc_src, reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       illegal_op;
    } ctl_t;

    ctl_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;
    bit    active = 1'b0;

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b001000, 6'b000010, 6'b000011};
    endfunction

    // Control word each phase must present, straight from the phase table
    function automatic ctl_t expect_ctl(input phase_t p, input logic rdy,
                                        input logic z, input logic [5:0] op);
        ctl_t e;
        e = '0;
        case (p)
            P_FETCH:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_we = rdy; e.pc_we = rdy; end
            P_DECODE: begin e.alu_src_b = 2'b11; e.illegal_op = !legal(op); end
            P_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            P_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
            P_MEMWB:  begin e.mem_to_reg = 2'b01; e.reg_we = 1; end
            P_MEMWR:  begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
            P_EXEC:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            P_ALUWB:  begin e.reg_dst = 2'b01; e.reg_we = 1; end
            P_ADDIEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            P_ADDIWB: begin e.reg_we = 1; end
            P_BRANCH: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_we = z; end
            P_JUMP:   begin e.pc_src = 2'b10; e.pc_we = 1; end
            P_JAL:    begin e.pc_src = 2'b10; e.pc_we = 1; e.reg_dst = 2'b10;
                            e.mem_to_reg = 2'b10; e.reg_we = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic ctl_t sample_ctl();
        ctl_t a;
        a.mem_req = mem_req; a.mem_we = mem_we; a.iord = iord; a.ir_we = ir_we;
        a.pc_we = pc_we; a.reg_we = reg_we; a.pc_src = pc_src; a.reg_dst = reg_dst;
        a.mem_to_reg = mem_to_reg; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b;
        a.alu_op = alu_op; a.illegal_op = illegal_op;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: actual %0h required %0h", nm, got, want);
    endtask

    // Monitor: one expected control word per active cycle
    always @(negedge clk) begin
        if (active) begin
            ctl_t  e;
            ctl_t  a;
            string n;
            a = sample_ctl();
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: actual %h required none", a);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (a === e) passed++;
                else $display("FAIL %s (opcode %b): actual %h required %h", n, opcode, a, e);
            end
        end
    end

    // One clock of stimulus; z > 1 picks a random zero flag
    task automatic cyc(input phase_t p, input logic rdy, input int z);
        mem_rdy = rdy;
        zero    = (z > 1) ? 1'($urandom) : z[0];
        funct   = 6'($urandom);
        exp_q.push_back(expect_ctl(p, rdy, zero, opcode));
        name_q.push_back(p.name());
        active = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int z);
        opcode = op;
        for (int i = 0; i < fw; i++) cyc(P_FETCH, 1'b0, 2);
        cyc(P_FETCH, 1'b1, 2);
        cyc(P_DECODE, 1'($urandom), 2);
        case (op)
            6'b000000: begin cyc(P_EXEC, 1'($urandom), 2); cyc(P_ALUWB, 1'($urandom), 2); end
            6'b100011: begin
                cyc(P_MEMADR, 1'($urandom), 2);
                for (int i = 0; i < mw; i++) cyc(P_MEMRD, 1'b0, 2);
                cyc(P_MEMRD, 1'b1, 2);
                cyc(P_MEMWB, 1'($urandom), 2);
            end
            6'b101011: begin
                cyc(P_MEMADR, 1'($urandom), 2);
                for (int i = 0; i < mw; i++) cyc(P_MEMWR, 1'b0, 2);
                cyc(P_MEMWR, 1'b1, 2);
            end
            6'b000100: cyc(P_BRANCH, 1'($urandom), z);
            6'b001000: begin cyc(P_ADDIEX, 1'($urandom), 2); cyc(P_ADDIWB, 1'($urandom), 2); end
            6'b000010: cyc(P_JUMP, 1'($urandom), 2);
            6'b000011: cyc(P_JAL, 1'($urandom), 2);
            default: ;
        endcase
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011};

        // Reset with mem_rdy high: no enable may escape
        rst = 1'b1; mem_rdy = 1'b1; zero = 1'b1; opcode = 6'b100011;
        #12;
        chk("reset_enables", 32'({pc_we, ir_we, reg_we, mem_we, mem_req, illegal_op}), 32'd0);
        chk("reset_state", 32'(state), 32'(S_FETCH));
        @(posedge clk); #1;
        chk("reset_enables_after_edge", 32'({pc_we, ir_we, reg_we, mem_we, mem_req, illegal_op}), 32'd0);
        chk("reset_state_after_edge", 32'(state), 32'(S_FETCH));
        mem_rdy = 1'b0;
        rst = 1'b0;

        // Directed instructions
        run_instr(6'b000000, 0, 0, 2);
        run_instr(6'b100011, 0, 2, 2);
        run_instr(6'b000100, 0, 0, 1);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000011, 0, 0, 2);
        run_instr(6'b111111, 0, 0, 2);
        run_instr(6'b001000, 1, 0, 2);
        run_instr(6'b101011, 0, 1, 2);
        run_instr(6'b000010, 2, 0, 2);

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            int k;
            k = int'($urandom_range(0, 7));
            if (k == 7) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end else begin
                op = ops[k];
            end
            run_instr(op, rand_wait(), rand_wait(), 2);
        end

        // Reset while a store is stalled on memory
        opcode = 6'b101011;
        cyc(P_FETCH, 1'b1, 2);
        cyc(P_DECODE, 1'b0, 2);
        cyc(P_MEMADR, 1'b0, 2);
        cyc(P_MEMWR, 1'b0, 2);
        active = 1'b0;
        mem_rdy = 1'b0;
        #1;
        chk("memwr_stalled_we", 32'(mem_we), 32'd1);
        chk("memwr_stalled_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("memwr_reset_we", 32'(mem_we), 32'd0);
        chk("memwr_reset_req", 32'(mem_req), 32'd0);
        chk("memwr_reset_state", 32'(state), 32'(S_FETCH));
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(6'b100011, 1, 1, 2);
        run_instr(6'b000000, 0, 0, 2);

        active = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all widths fixed for MIPS32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  instr[31:26] from instruction register.
REQ-005 funct  in  6  instr[5:0]; routed only via alu_op=10 encoding, not decoded here.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_rdy  in  1  memory completes current request this cycle.
REQ-008 mem_req  out  1  memory request; held until mem_rdy sampled high.
REQ-009 mem_we  out  1  write request qualifier.
REQ-010 iord  out  1  address mux select: 0 PC, 1 ALUOut.
REQ-011 ir_we, pc_we, reg_we  out  1 each  write enables.
REQ-012 pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 reg_dst  out  2  write-register 3:1 select: 00 rt, 01 rd, 10 const 31.
REQ-014 mem_to_reg  out  2  write-data 3:1 select: 00 ALUOut, 01 MDR, 10 PC.
REQ-015 alu_src_a  out  1  0 PC, 1 regA; alu_src_b  out  2  00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2.
REQ-016 alu_op  out  2  00 add, 01 sub, 10 per funct.
REQ-017 illegal_op  out  1  one-cycle pulse on unsupported opcode; state  out  4  debug.

Function
REQ-018 Moore FSM; outputs decoded from state; only pc_we/ir_we/mem_rdy-gated fields combine inputs; every field not listed for a state is 0.
REQ-019 FETCH: mem_req=1, iord=0, a=0, b=01, op=00, pc_src=00, ir_we=pc_we=mem_rdy; stay until mem_rdy, then DECODE.
REQ-020 DECODE: a=0, b=11, op=00; next: 000000 EXEC, 100011/101011 MEMADR, 000100 BRANCH, 001000 ADDIEX, 000010 JUMP, 000011 JAL, other FETCH with illegal_op=1.
REQ-021 MEMADR: a=1, b=10, op=00; next MEMRD (lw) or MEMWR (sw).
REQ-022 MEMRD: mem_req=1, iord=1; stay until mem_rdy, then MEMWB.
REQ-023 MEMWB: reg_dst=00, mem_to_reg=01, reg_we=1; next FETCH.
REQ-024 MEMWR: mem_req=1, mem_we=1, iord=1; stay until mem_rdy, then FETCH.
REQ-025 EXEC: a=1, b=00, op=10; next ALUWB. ALUWB: reg_dst=01, mem_to_reg=00, reg_we=1; next FETCH.
REQ-026 ADDIEX: a=1, b=10, op=00; next ADDIWB. ADDIWB: reg_dst=00, mem_to_reg=00, reg_we=1; next FETCH.
REQ-027 BRANCH: a=1, b=00, op=01, pc_src=01, pc_we=zero; next FETCH.
REQ-028 JUMP: pc_src=10, pc_we=1; next FETCH. JAL: as JUMP plus reg_dst=10, mem_to_reg=10, reg_we=1.
REQ-029 Latency with mem_rdy=1: beq/j/jal 3, R/addi/sw 4, lw 5 cycles; each mem_rdy-low cycle in FETCH/MEMRD/MEMWR adds one.
REQ-030 mem_req/mem_we/iord stable while waiting; no write enable other than in REQ-019/024 depends on mem_rdy.
REQ-031 Unused state encodings transition to FETCH with all enables 0.

Reset
REQ-032 rst high: state=FETCH immediately; pc_we, ir_we, reg_we, mem_we, mem_req, illegal_op forced 0 while rst high.
REQ-033 Reset mid-transaction aborts it; first FETCH request on first edge after deassertion.

Structure
REQ-034 Shared package/header mips_defs holds opcode values, state encodings and all select encodings of REQ-012..016.
REQ-035 One sub-module natural: ctrl_out_dec, combinational state-to-control decoder; next-state logic and state register stay in multicycle_ctrl.

Verification
REQ-036 R-type 000000/100000, mem_rdy=1 -> 4 cycles; cycle 4 reg_we=1, reg_dst=01, mem_to_reg=00.
REQ-037 lw 100011, mem_rdy low 2 cycles in MEMRD -> 7 cycles; iord=1 for 3 cycles; MEMWB mem_to_reg=01.
REQ-038 beq 000100 with zero=1 then zero=0 -> cycle 3 pc_src=01; pc_we=1 only when zero=1.
REQ-039 jal 000011 -> cycle 3 pc_we=1, pc_src=10, reg_we=1, reg_dst=10, mem_to_reg=10.
REQ-040 opcode 111111 -> illegal_op=1 in DECODE only; back to FETCH; no write enable asserted.
REQ-041 rst asserted mid-MEMWR with mem_rdy=0 -> mem_we, mem_req drop same cycle; state=FETCH.
